// File: rtl/otter_arb_pkg.sv
// rtl/otter_arb_pkg.sv - shared types and constants for the memory port-2 arbiter
package otter_arb_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t;
    typedef enum logic [1:0] {IDLE, CPU_RET, VGA_RET} ret_state_t;

    localparam logic [1:0]  MEM_SIZE_BYTE    = 2'b00;
    localparam logic [31:0] VGA_BASE_DEFAULT = 32'h0001_0000;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of denied VGA request cycles
module arb_starve_cnt #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == MAX_VAL);

endmodule

// File: rtl/mem2_vga_arbiter.sv
// rtl/mem2_vga_arbiter.sv - CPU/VGA arbiter for memory port 2; ARB_STATS_EN adds stall/grant counters
module mem2_vga_arbiter
    import otter_arb_pkg::*;
#(
    parameter logic [31:0] VGA_BASE   = VGA_BASE_DEFAULT,
    parameter int          STARVE_MAX = 4,
    parameter int          CNT_W      = 4
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic        cpu_rden,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    output logic        cpu_halt,
    input  logic        vga_req,
    input  logic [15:0] vga_addr,
    output logic        vga_gnt,
    output logic        vga_valid,
    output logic [7:0]  vga_data,
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic [31:0] mem_addr2,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
`ifdef ARB_STATS_EN
    output logic [15:0] stall_cycles,
    output logic [15:0] vga_grants,
`endif
    input  logic [31:0] mem_dout2
);

    owner_t     w_owner;
    ret_state_t r_state, w_state_nxt;
    logic       w_cpu_req, w_at_max, w_forced, w_inc;

    assign w_cpu_req = cpu_rden | cpu_we;
    assign w_forced  = w_at_max & vga_req;

    // Owner is gated by reset so every memory-facing output reads 0 while held.
    always_comb begin
        w_owner = OWN_NONE;
        if (RST_N) begin
            if (w_cpu_req && !w_forced) w_owner = OWN_CPU;
            else if (vga_req)           w_owner = OWN_VGA;
        end
    end

    always_comb begin
        mem_rden2   = 1'b0;
        mem_we2     = 1'b0;
        mem_addr2   = '0;
        mem_size    = '0;
        mem_sign    = 1'b0;
        w_state_nxt = IDLE;
        case (w_owner)
            OWN_CPU: begin
                mem_rden2   = cpu_rden;
                mem_we2     = cpu_we;
                mem_addr2   = cpu_addr;
                mem_size    = cpu_size;
                mem_sign    = cpu_sign;
                w_state_nxt = cpu_rden ? CPU_RET : IDLE;
            end
            OWN_VGA: begin
                mem_rden2   = 1'b1;
                mem_addr2   = VGA_BASE + {16'b0, vga_addr};
                mem_size    = MEM_SIZE_BYTE;
                mem_sign    = 1'b1;
                w_state_nxt = VGA_RET;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    assign cpu_halt  = (w_owner == OWN_VGA) & w_cpu_req;
    assign vga_gnt   = (w_owner == OWN_VGA);
    // Memory reads are synchronous, so the byte is on mem_dout2 during the return cycle.
    assign vga_valid = (r_state == VGA_RET);
    assign vga_data  = vga_valid ? mem_dout2[7:0] : 8'h00;

    // Any cycle that is not a CPU win over a pending VGA request resets starvation.
    assign w_inc = (w_owner == OWN_CPU) & vga_req;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (RST_N),
        .i_inc    (w_inc),
        .i_clr    (!w_inc),
        .o_at_max (w_at_max)
    );

`ifdef ARB_STATS_EN
    logic [15:0] r_stall_cycles, r_vga_grants;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cycles <= '0;
            r_vga_grants   <= '0;
        end else begin
            if (cpu_halt && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (vga_gnt && (r_vga_grants != 16'hFFFF))    r_vga_grants   <= r_vga_grants + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign vga_grants   = r_vga_grants;
`endif

endmodule

// File: tb/tb_mem2_vga_arbiter.sv
// tb/tb_mem2_vga_arbiter.sv - directed self-checking bench for mem2_vga_arbiter
module tb_mem2_vga_arbiter;

    logic        clk = 1'b0;
    logic        RST_N;
    logic        cpu_rden, cpu_we, cpu_sign, vga_req;
    logic [31:0] cpu_addr, mem_dout2;
    logic [1:0]  cpu_size;
    logic [15:0] vga_addr;
    logic        cpu_halt, vga_gnt, vga_valid, mem_rden2, mem_we2, mem_sign;
    logic [7:0]  vga_data;
    logic [31:0] mem_addr2;
    logic [1:0]  mem_size;
`ifdef ARB_STATS_EN
    logic [15:0] stall_cycles, vga_grants;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem2_vga_arbiter dut (
        .clk(clk), .RST_N(RST_N),
        .cpu_rden(cpu_rden), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_halt(cpu_halt),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_valid(vga_valid), .vga_data(vga_data),
        .mem_rden2(mem_rden2), .mem_we2(mem_we2), .mem_addr2(mem_addr2),
        .mem_size(mem_size), .mem_sign(mem_sign),
`ifdef ARB_STATS_EN
        .stall_cycles(stall_cycles), .vga_grants(vga_grants),
`endif
        .mem_dout2(mem_dout2)
    );

    task automatic idle_inputs();
        cpu_rden = 0; cpu_we = 0; cpu_addr = 0; cpu_size = 0; cpu_sign = 0;
        vga_req = 0; vga_addr = 0; mem_dout2 = 0;
    endtask

    // Advance one clock, then settle just after the edge.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_N = 0;
        next_cycle(); next_cycle();
        RST_N = 1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        RST_N = 0;
        cpu_rden = 1; cpu_addr = 32'h0000_1234; vga_req = 1; mem_dout2 = 32'hFFFF_FFFF;
        next_cycle(); #1;
        if (cpu_halt !== 1'b0)   begin $display("FAIL reset_halt got %b exp 0", cpu_halt); nerr++; end nvec++;
        if (vga_gnt !== 1'b0)    begin $display("FAIL reset_gnt got %b exp 0", vga_gnt); nerr++; end nvec++;
        if (vga_valid !== 1'b0)  begin $display("FAIL reset_valid got %b exp 0", vga_valid); nerr++; end nvec++;
        if (vga_data !== 8'h00)  begin $display("FAIL reset_data got %h exp 00", vga_data); nerr++; end nvec++;
        if (mem_rden2 !== 1'b0)  begin $display("FAIL reset_rden got %b exp 0", mem_rden2); nerr++; end nvec++;
        if (mem_addr2 !== 32'h0) begin $display("FAIL reset_addr got %h exp 0", mem_addr2); nerr++; end nvec++;
        idle_inputs();
        RST_N = 1;
        next_cycle();
    endtask

    task automatic test_vga_only();
        vga_req = 1; vga_addr = 16'h0005; mem_dout2 = 32'hAABB_CC3C; #1;
        if (vga_gnt !== 1'b1)          begin $display("FAIL vga_gnt got %b exp 1", vga_gnt); nerr++; end nvec++;
        if (mem_addr2 !== 32'h0001_0005) begin $display("FAIL vga_addr got %h exp 00010005", mem_addr2); nerr++; end nvec++;
        if ({mem_rden2, mem_we2, mem_size, mem_sign} !== 5'b10_001)
            begin $display("FAIL vga_memctl got %b exp 10001", {mem_rden2, mem_we2, mem_size, mem_sign}); nerr++; end nvec++;
        if (vga_valid !== 1'b0)        begin $display("FAIL vga_valid_early got %b exp 0", vga_valid); nerr++; end nvec++;
        next_cycle();
        vga_req = 0; #1;
        if (vga_valid !== 1'b1)        begin $display("FAIL vga_valid got %b exp 1", vga_valid); nerr++; end nvec++;
        if (vga_data !== 8'h3C)        begin $display("FAIL vga_data got %h exp 3c", vga_data); nerr++; end nvec++;
        next_cycle(); #1;
        if (vga_valid !== 1'b0)        begin $display("FAIL vga_valid_drop got %b exp 0", vga_valid); nerr++; end nvec++;
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        vga_req = 1; vga_addr = 16'h0010; mem_dout2 = 32'h0; #1;
        if (mem_addr2 !== 32'h0001_0010) begin $display("FAIL b2b_addr0 got %h exp 00010010", mem_addr2); nerr++; end nvec++;
        next_cycle();
        vga_addr = 16'hFFFF; mem_dout2 = 32'h1122_3344; #1;
        if (vga_gnt !== 1'b1)            begin $display("FAIL b2b_gnt1 got %b exp 1", vga_gnt); nerr++; end nvec++;
        if (mem_addr2 !== 32'h0001_FFFF) begin $display("FAIL b2b_addr1 got %h exp 0001ffff", mem_addr2); nerr++; end nvec++;
        if ({vga_valid, vga_data} !== 9'h1_44) begin $display("FAIL b2b_data0 got %b/%h exp 1/44", vga_valid, vga_data); nerr++; end nvec++;
        next_cycle();
        vga_req = 0; mem_dout2 = 32'h0000_0055; #1;
        if ({vga_valid, vga_data} !== 9'h1_55) begin $display("FAIL b2b_data1 got %b/%h exp 1/55", vga_valid, vga_data); nerr++; end nvec++;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_simultaneous();
        cpu_rden = 1; cpu_addr = 32'h0000_0100; cpu_size = 2'b10; cpu_sign = 0;
        vga_req = 1; vga_addr = 16'h0001; #1;
        if (cpu_halt !== 1'b0)         begin $display("FAIL sim_halt got %b exp 0", cpu_halt); nerr++; end nvec++;
        if (vga_gnt !== 1'b0)          begin $display("FAIL sim_gnt got %b exp 0", vga_gnt); nerr++; end nvec++;
        if (mem_addr2 !== 32'h0000_0100) begin $display("FAIL sim_addr got %h exp 00000100", mem_addr2); nerr++; end nvec++;
        if ({mem_rden2, mem_we2, mem_size, mem_sign} !== 5'b10_100)
            begin $display("FAIL sim_memctl got %b exp 10100", {mem_rden2, mem_we2, mem_size, mem_sign}); nerr++; end nvec++;
        idle_inputs();
        next_cycle();
    endtask

    // Four denied cycles saturate the counter; the fifth is forced to VGA.
    task automatic test_starvation();
        cpu_rden = 1; cpu_addr = 32'h0000_0200; cpu_size = 2'b10; vga_req = 1; vga_addr = 16'h0020;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                #1;
                if ({vga_gnt, cpu_halt} !== 2'b00) begin $display("FAIL starve_deny r%0d c%0d got %b exp 00", r, i, {vga_gnt, cpu_halt}); nerr++; end nvec++;
                next_cycle();
            end
            #1;
            if ({vga_gnt, cpu_halt, mem_we2} !== 3'b110) begin $display("FAIL starve_force r%0d got %b exp 110", r, {vga_gnt, cpu_halt, mem_we2}); nerr++; end nvec++;
            if (mem_addr2 !== 32'h0001_0020) begin $display("FAIL starve_addr r%0d got %h exp 00010020", r, mem_addr2); nerr++; end nvec++;
            next_cycle();
        end
        #1;
        if ({vga_gnt, cpu_halt, vga_valid} !== 3'b001) begin $display("FAIL starve_regrant got %b exp 001", {vga_gnt, cpu_halt, vga_valid}); nerr++; end nvec++;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_write_force();
        cpu_rden = 1; cpu_addr = 32'h0000_0300; vga_req = 1; vga_addr = 16'h0030;
        repeat (4) next_cycle();
        cpu_rden = 0; cpu_we = 1; cpu_size = 2'b01; #1;
        if ({cpu_halt, mem_we2, mem_rden2} !== 3'b101) begin $display("FAIL wf_block got %b exp 101", {cpu_halt, mem_we2, mem_rden2}); nerr++; end nvec++;
        next_cycle(); #1;
        if ({cpu_halt, mem_we2, mem_size} !== 4'b0101) begin $display("FAIL wf_issue got %b exp 0101", {cpu_halt, mem_we2, mem_size}); nerr++; end nvec++;
        if (mem_addr2 !== 32'h0000_0300) begin $display("FAIL wf_addr got %h exp 00000300", mem_addr2); nerr++; end nvec++;
        idle_inputs();
        next_cycle();
    endtask

    // A single cycle without vga_req must restart the starvation count.
    task automatic test_req_drop();
        cpu_rden = 1; cpu_addr = 32'h0000_0400; vga_req = 1;
        repeat (3) next_cycle();
        vga_req = 0;
        next_cycle();
        vga_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (vga_gnt !== 1'b0) begin $display("FAIL drop_deny c%0d got %b exp 0", i, vga_gnt); nerr++; end nvec++;
            next_cycle();
        end
        #1;
        if (vga_gnt !== 1'b1) begin $display("FAIL drop_force got %b exp 1", vga_gnt); nerr++; end nvec++;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_async_reset();
        vga_req = 1; vga_addr = 16'h0040; mem_dout2 = 32'h0000_00FF;
        next_cycle();
        vga_req = 0; #1;
        if ({vga_valid, vga_data} !== 9'h1_FF) begin $display("FAIL ar_pre got %b/%h exp 1/ff", vga_valid, vga_data); nerr++; end nvec++;
        RST_N = 0; #1;
        if ({vga_valid, vga_data} !== 9'h0_00) begin $display("FAIL ar_drop got %b/%h exp 0/00", vga_valid, vga_data); nerr++; end nvec++;
        next_cycle();
        RST_N = 1;
        idle_inputs();
        next_cycle(); #1;
        if (vga_valid !== 1'b0) begin $display("FAIL ar_after got %b exp 0", vga_valid); nerr++; end nvec++;
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        cpu_rden = 1; cpu_addr = 32'h0000_0500; vga_req = 1;
        repeat (15) next_cycle();
        idle_inputs();
        next_cycle();
        if (stall_cycles !== 16'd3) begin $display("FAIL stats_stall got %0d exp 3", stall_cycles); nerr++; end nvec++;
        if (vga_grants !== 16'd3)   begin $display("FAIL stats_grants got %0d exp 3", vga_grants); nerr++; end nvec++;
    endtask
`endif

    initial begin
        idle_inputs();
        RST_N = 1;
        #2;
        test_reset();
        test_vga_only();
        test_back_to_back();
        test_simultaneous();
        test_starvation();
        test_write_force();
        test_req_drop();
        test_async_reset();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
